regfile_mp: RTL and testbench

Parametrised multi-port register file for the pipelined datapath, succeeding the fixed 32x32 two-read-port register file. It has NUM_RD registered read ports, one write port with write-to-read bypass, and an optional hardwired-zero register 0. It also keeps a per-register pending-write scoreboard, so decode can detect RAW hazards without a separate hazard table. It sits between the decode stage (reads, claims) and the writeback stage (writes).

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_scoreboard.sv | 35 +++
 rtl/regfile_mp.sv | 56 +++++
 tb/tb_regfile_mp.sv | 114 +++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared default sizes and the hardwired-zero address for the register file
package regfile_pkg;
  localparam int DATA_W_D = 32;
  localparam int ADDR_W_D = 5;
  localparam int NUM_RD_D = 2;
  localparam int ZERO_ADDR = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits (claim sets, write clears, claim wins); ports: clk, rst (async active-low), set_en/set_addr, clr_en/clr_addr, lk_addr -> lk_cur/lk_nxt lookups, busy_vec
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W = ADDR_W_D,
  parameter int NUM_RD = NUM_RD_D,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] lk_addr,
  output logic [2**ADDR_W-1:0]     busy_vec,
  output logic [NUM_RD-1:0]        lk_cur,
  output logic [NUM_RD-1:0]        lk_nxt
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0] busy_nxt;
  always_comb begin
    busy_nxt = busy_vec;
    for (int r = 0; r < DEPTH; r++)
      busy_nxt[r] = (ZERO_REG != 0 && r == ZERO_ADDR) ? 1'b0 :
                    (set_en && set_addr == ADDR_W'(r)) ? 1'b1 :
                    (clr_en && clr_addr == ADDR_W'(r)) ? 1'b0 : busy_vec[r];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) busy_vec <= '0;
    else busy_vec <= busy_nxt;
  // lk_nxt is the post-update view, used when a read is bypassed from the same-cycle write
  for (genvar i = 0; i < NUM_RD; i++) begin : g_lk
    assign lk_cur[i] = busy_vec[lk_addr[i*ADDR_W +: ADDR_W]];
    assign lk_nxt[i] = busy_nxt[lk_addr[i*ADDR_W +: ADDR_W]];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with registered reads, write bypass, optional zero register and RAW scoreboard; ports: clk, rst (async active-low), rd_hold, rd_addr/rd_data/rd_busy per port, wr_en/wr_addr/wr_data, claim_en/claim_addr, busy_vec
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int NUM_RD = NUM_RD_D,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_hold,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [NUM_RD-1:0] lk_cur, lk_nxt;
  logic wr_ok;
  assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == ZA);
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    else if (wr_ok) mem[wr_addr] <= wr_data;
  regfile_scoreboard #(.ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .rst(rst),
    .set_en(claim_en), .set_addr(claim_addr),
    .clr_en(wr_en), .clr_addr(wr_addr),
    .lk_addr(rd_addr), .busy_vec(busy_vec),
    .lk_cur(lk_cur), .lk_nxt(lk_nxt)
  );
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] q;
    logic qb, byp, zr;
    assign ra = rd_addr[i*ADDR_W +: ADDR_W];
    assign byp = BYPASS != 0 && wr_ok && wr_addr == ra;
    assign zr = ZERO_REG != 0 && ra == ZA;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        q <= '0;
        qb <= 1'b0;
      end else if (!rd_hold) begin
        q <= zr ? '0 : byp ? wr_data : mem[ra];
        qb <= zr ? 1'b0 : byp ? lk_nxt[i] : lk_cur[i];
      end
    assign rd_data[i*DATA_W +: DATA_W] = q;
    assign rd_busy[i] = qb;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks on a 4-port bypassing zero-reg instance and a 2-port plain instance
module tb_regfile_mp;
  logic clk = 0, rst = 0, rd_hold = 0, wr_en = 0, claim_en = 0;
  logic [4:0] wr_addr = 0, claim_addr = 0;
  logic [31:0] wr_data = 0;
  logic [19:0] ra_a = 0;
  logic [9:0] ra_b = 0;
  logic [127:0] rd_a;
  logic [63:0] rd_b;
  logic [3:0] bz_a;
  logic [1:0] bz_b;
  logic [31:0] bv_a, bv_b;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  regfile_mp #(.NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .rd_hold(rd_hold), .rd_addr(ra_a), .rd_data(rd_a), .rd_busy(bz_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(bv_a)
  );
  regfile_mp #(.NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rd_hold(rd_hold), .rd_addr(ra_b), .rd_data(rd_b), .rd_busy(bz_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(bv_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    step();
    chk("rst_rd", rd_a[31:0], 32'h0);
    chk("rst_bv", bv_a, 32'h0);
    rst = 1;
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; claim_en = 1; claim_addr = 2;
    step();
    wr_en = 0; claim_en = 0; ra_a[4:0] = 5;
    chk("claim_r2", bv_a, 32'h4);
    step();
    chk("rd_r5", rd_a[31:0], 32'hDEADBEEF);
    #3 rst = 0;
    #1;
    chk("async_rd", rd_a[31:0], 32'h0);
    chk("async_bv", bv_a, 32'h0);
    chk("async_bv_b", bv_b, 32'h0);
    #1 rst = 1;
    step();
    chk("r5_after_rst", rd_a[31:0], 32'h0);
    wr_en = 1; wr_addr = 7; wr_data = 32'h12345678; claim_en = 1; claim_addr = 7;
    ra_a[4:0] = 7; ra_b[4:0] = 7;
    step();
    chk("byp_data", rd_a[31:0], 32'h12345678);
    chk("byp_busy", {31'b0, bz_a[0]}, 32'h1);
    chk("nobyp_data", rd_b[31:0], 32'h0);
    chk("nobyp_busy", {31'b0, bz_b[0]}, 32'h0);
    wr_en = 0; claim_en = 0;
    step();
    chk("nobyp_next", rd_b[31:0], 32'h12345678);
    chk("nobyp_busy_next", {31'b0, bz_b[0]}, 32'h1);
    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; claim_en = 1; claim_addr = 0;
    ra_a[4:0] = 0; ra_b[4:0] = 0;
    step();
    chk("zr_byp", rd_a[31:0], 32'h0);
    chk("nz_old", rd_b[31:0], 32'h0);
    wr_en = 0; claim_en = 0;
    step();
    chk("zr_rd", rd_a[31:0], 32'h0);
    chk("zr_busy", {31'b0, bz_a[0]}, 32'h0);
    chk("zr_bv", bv_a, 32'h80);
    chk("nz_rd", rd_b[31:0], 32'hFFFFFFFF);
    chk("nz_busy", {31'b0, bz_b[0]}, 32'h1);
    chk("nz_bv", bv_b, 32'h81);
    claim_en = 1; claim_addr = 3;
    step();
    chk("sb_claim", bv_a, 32'h88);
    claim_en = 0; wr_en = 1; wr_addr = 3; wr_data = 32'h33;
    step();
    chk("sb_clear", bv_a, 32'h80);
    claim_en = 1; claim_addr = 3;
    step();
    chk("sb_both", bv_a, 32'h88);
    claim_en = 0;
    step();
    chk("sb_clear2", bv_a, 32'h80);
    wr_addr = 9; wr_data = 32'hA5A5A5A5; rd_hold = 1; ra_a[9:5] = 9; ra_b[9:5] = 9;
    step();
    chk("hold_a", rd_a[63:32], 32'h0);
    chk("hold_b", rd_b[63:32], 32'hFFFFFFFF);
    wr_en = 0; rd_hold = 0;
    step();
    chk("rel_a", rd_a[63:32], 32'hA5A5A5A5);
    chk("rel_b", rd_b[63:32], 32'hA5A5A5A5);
    wr_en = 1; wr_addr = 12; wr_data = 32'h0000BEEF;
    step();
    wr_addr = 1; wr_data = 32'h11111111;
    step();
    wr_en = 0; ra_a = {5'd1, 5'd12, 5'd12, 5'd12};
    step();
    chk("mp0", rd_a[31:0], 32'h0000BEEF);
    chk("mp1", rd_a[63:32], 32'h0000BEEF);
    chk("mp2", rd_a[95:64], 32'h0000BEEF);
    chk("mp3", rd_a[127:96], 32'h11111111);
    chk("mp_busy", {28'b0, bz_a}, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
